// File: rtl/restoring_divider_if.sv
// Handshake/result bundle for restoring_divider.
// master drives the request, slave returns the result.
interface restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes, then sign-fixed.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           r_state;
  // r_dvd shifts dividend bits out and quotient bits in
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_n;
  logic             r_neg_d;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_neg_n;
  logic             w_neg_d;
  logic [WIDTH-1:0] w_mag_n;
  logic [WIDTH-1:0] w_mag_d;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic             w_unused;

  // Operand signs only matter in signed mode.
  assign w_neg_n = bus.signed_mode & bus.dividend[WIDTH-1];
  assign w_neg_d = bus.signed_mode & bus.divisor[WIDTH-1];
  assign w_mag_n = w_neg_n ? -bus.dividend : bus.dividend;
  assign w_mag_d = w_neg_d ? -bus.divisor : bus.divisor;

  // Partial remainder stays below the divisor, so its MSB is always 0.
  assign w_sh     = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_diff   = w_sh - {1'b0, r_dvs};
  assign w_qbit   = ~w_diff[WIDTH];
  assign w_unused = r_rem[WIDTH];

  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rmd;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

  // Control FSM, datapath steps and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_n <= 1'b0;
      r_neg_d <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_quo   <= '1;
              r_rmd   <= bus.dividend;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dvd   <= w_mag_n;
              r_dvs   <= w_mag_d;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH);
              r_neg_n <= w_neg_n;
              r_neg_d <= w_neg_d;
              r_dbz   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_qbit ? w_diff : w_sh;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quo   <= (r_neg_n ^ r_neg_d) ? -r_dvd : r_dvd;
          r_rmd   <= r_neg_n ? -r_rem[WIDTH-1:0]
                             : r_rem[WIDTH-1:0];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=8).
// Vector table plus hand-written corner sequences, queue scoreboard.
module tb_restoring_divider;
  typedef struct {
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  int   cyc;
  exp_t sb[$];
  vec_t tbl[13];

  restoring_divider_if #(.WIDTH(8)) bus ();

  restoring_divider #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.done) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic sm, input logic [7:0] a,
                       input logic [7:0] b);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Caller sits #1 after an edge; lat0 = cycles since start edge.
  task automatic wait_done(input int lat0, output int lat,
                           output bit ok);
    lat = lat0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = bus.done;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen after %0d cycles", lat);
    end
  endtask

  task automatic check_result(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at done", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " quotient"}, 32'(bus.quotient), 32'(e.q));
    chk({tag, " remainder"}, 32'(bus.remainder), 32'(e.r));
    chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
    chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, 32'(bus.done), 32'd0);
    chk({tag, " quotient hold"}, 32'(bus.quotient), 32'(e.q));
    chk({tag, " remainder hold"}, 32'(bus.remainder), 32'(e.r));
  endtask

  task automatic push(input logic [7:0] q, input logic [7:0] r,
                      input logic dbz);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.lat = dbz ? 1 : 10;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit ok;
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue(v.sm, v.a, v.b);
    push(v.q, v.r, v.dbz);
    if (!v.dbz) chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    wait_done(1, lat, ok);
    if (ok) check_result(tag, lat);
    else void'(sb.pop_front());
  endtask

  initial begin
    int lat;
    int c1;
    int d0;
    bit ok;

    tbl[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    tbl[1]  = '{1'b0, 8'd13,  8'd0,   8'hFF,  8'd13,  1'b1};
    tbl[2]  = '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0};
    tbl[3]  = '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0};
    tbl[4]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0};
    tbl[5]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[6]  = '{1'b0, 8'd50,  8'd5,   8'd10,  8'd0,   1'b0};
    tbl[7]  = '{1'b1, 8'h9C,  8'hF9,  8'h0E,  8'hFE,  1'b0};
    tbl[8]  = '{1'b0, 8'd7,   8'd200, 8'd0,   8'd7,   1'b0};
    tbl[9]  = '{1'b1, 8'hFB,  8'h00,  8'hFF,  8'hFB,  1'b1};
    tbl[10] = '{1'b0, 8'd200, 8'd3,   8'd66,  8'd2,   1'b0};
    tbl[11] = '{1'b1, 8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0};
    tbl[12] = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0};

    checks          = 0;
    errors          = 0;
    done_cnt        = 0;
    cyc             = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", 32'(bus.quotient), 32'd0);
    chk("reset remainder", 32'(bus.remainder), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // Second start with new operands while busy must be ignored.
    d0 = done_cnt;
    issue(1'b0, 8'd100, 8'd7);
    push(8'd14, 8'd2, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = 1'b1;
    bus.dividend    = 8'd200;
    bus.divisor     = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(4, lat, ok);
    if (ok) check_result("busy_start", lat);
    else void'(sb.pop_front());
    repeat (12) @(posedge clk);
    #1;
    chk("busy_start done count", 32'(done_cnt - d0), 32'd1);

    // Reset in cycle 5 of 200/3 aborts it without a done pulse.
    issue(1'b0, 8'd200, 8'd3);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort quotient", 32'(bus.quotient), 32'd0);
    chk("abort remainder", 32'(bus.remainder), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort no done", 32'(done_cnt - d0), 32'd0);
    issue(1'b0, 8'd50, 8'd5);
    push(8'd10, 8'd0, 1'b0);
    wait_done(1, lat, ok);
    if (ok) check_result("after_abort", lat);
    else void'(sb.pop_front());

    // Start held high: back-to-back ops with one idle cycle between.
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.dividend    = 8'd100;
    bus.divisor     = 8'd7;
    push(8'd14, 8'd2, 1'b0);
    push(8'd14, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    wait_done(1, lat, ok);
    c1 = cyc;
    if (ok) begin
      void'(sb.pop_front());
      chk("held first latency", 32'(lat), 32'd10);
      chk("held first quotient", 32'(bus.quotient), 32'd14);
      @(posedge clk);
      #1;
      wait_done(1, lat, ok);
      bus.start = 1'b0;
      if (ok) begin
        void'(sb.pop_front());
        chk("held gap", 32'(cyc - c1), 32'd11);
        chk("held second remainder", 32'(bus.remainder), 32'd2);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("held idle busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
